// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Stall-vector, flush, payload and status bundle of a pipeline
//               inter-stage register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
    parameter int DATA_W  = 105,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [3:0]         occ;
    logic [31:0]        perf_bubbles;
    logic [31:0]        perf_holds;

    modport master (
        output stall, flush, in_valid, in_data,
        input  out_valid, out_data, occ, perf_bubbles, perf_holds
    );

    modport slave (
        input  stall, flush, in_valid, in_data,
        output out_valid, out_data, occ, perf_bubbles, perf_holds
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : DEPTH-slice pipeline register with stall-vector hold/bubble,
//               flush and occupancy. Optional counters: PIPE_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int              DATA_W    = 105,
    parameter int              DEPTH     = 1,
    parameter int              STALL_W   = 6,
    parameter int              STAGE_IDX = 4,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_stage_reg_if.slave   bus
);

    logic              s_cur;
    logic              s_nxt;
    logic              advance;
    logic              bubble;
    logic              hold;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [3:0]        occ_q;
    logic [3:0]        occ_d;

    assign s_cur   = bus.stall[STAGE_IDX];
    assign s_nxt   = bus.stall[STAGE_IDX+1];
    assign advance = !s_cur;
    assign bubble  = s_cur & !s_nxt;
    assign hold    = s_cur & s_nxt;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) data_d[k] = NOP_VALUE;
        end else if (bubble || advance) begin
            // Downstream slices drain in both cases; only slice 0's source differs.
            for (int k = DEPTH - 1; k >= 1; k--) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            data_d[0]  = bubble ? NOP_VALUE : bus.in_data;
            valid_d[0] = bubble ? 1'b0 : bus.in_valid;
        end
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) occ_d = occ_d + {3'b000, valid_d[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= NOP_VALUE;
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.occ       = occ_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] bubbles_q;
    logic [31:0] bubbles_d;
    logic [31:0] holds_q;
    logic [31:0] holds_d;

    // Saturating counters; flush suppresses counting but never clears them.
    always_comb begin
        bubbles_d = bubbles_q;
        holds_d   = holds_q;
        if (!bus.flush && bubble && (bubbles_q != 32'hFFFF_FFFF)) bubbles_d = bubbles_q + 32'd1;
        if (!bus.flush && hold && (holds_q != 32'hFFFF_FFFF))     holds_d   = holds_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubbles_q <= '0;
            holds_q   <= '0;
        end else begin
            bubbles_q <= bubbles_d;
            holds_q   <= holds_d;
        end
    end

    assign bus.perf_bubbles = bubbles_q;
    assign bus.perf_holds   = holds_q;
`else
    assign bus.perf_bubbles = 32'h0;
    assign bus.perf_holds   = 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register. It is the generic successor of the fixed MEM/WB latch used between the CPU pipeline stages. It carries an arbitrary-width payload through DEPTH register slices with a valid bit per slice. It implements the core-wide stall-vector protocol (hold, bubble insertion, advance), plus a synchronous flush, an occupancy count and optional performance counters. It is instantiated between any two stages, e.g. EX/MEM or MEM/WB, and for extra retiming slices.

Parameters:
DATA_W, 105, payload width in bits; the default matches the write-back bundle (waddr 5, we 1, wdata 32, whilo 1, hi 32, lo 32, LLbit_we 1, LLbit_value 1).
DEPTH, 1, number of register slices, 1..15.
STALL_W, 6, width of the core stall vector.
STAGE_IDX, 4, index of this register's own stage bit in the stall vector; must be ≤ STALL_W-2.
NOP_VALUE, {DATA_W{1'b0}}, payload loaded on reset, bubble or flush.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  synchronous reset, active-high (`RstEnable).
stall  in  STALL_W  core stall vector, `StallEnable = 1.
flush  in  1  synchronous kill of all slices.
in_valid  in  1  upstream slot holds a real instruction.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  valid of the last slice.
out_data  out  DATA_W  payload of the last slice.
occ  out  4  number of slices with valid = 1.
perf_bubbles  out  32  bubbles inserted (feature-gated).
perf_holds  out  32  hold cycles (feature-gated).

Behaviour:
- Slices are numbered 0..DEPTH-1. Slice 0 captures from the input; out_* is driven by slice DEPTH-1. Latency is DEPTH cycles when no stall occurs.
- Per-cycle decode:
  - s_cur = stall[STAGE_IDX]
  - s_nxt = stall[STAGE_IDX+1]
  - ADVANCE = !s_cur
  - BUBBLE = s_cur & !s_nxt
  - HOLD = s_cur & s_nxt
- Priority at each posedge: rst > flush > BUBBLE > ADVANCE > HOLD.
- rst: every slice gets valid = 0 and data = NOP_VALUE. Result: out_valid = 0, out_data = NOP_VALUE, occ = 0, perf counters = 0.
- flush: every slice gets valid = 0 and data = NOP_VALUE; occ goes to 0 on the next cycle. The stall vector is ignored in that cycle. in_* is discarded even if ADVANCE holds.
- ADVANCE: slice0 ← {in_valid, in_data}; slice k ← slice k-1 for k ≥ 1.
- BUBBLE: slice0 ← {0, NOP_VALUE}; slice k ← slice k-1. Downstream keeps draining while this stage is stalled. in_* is not captured; upstream holds it under its own stall bit.
- HOLD: all slices retain their contents.
- When in_valid = 0 under ADVANCE, in_data is still captured verbatim. Downstream qualifies on valid and on the write-enable bits inside the payload.
- occ is registered and equals the popcount of the slice valid bits after the edge. It never exceeds DEPTH; there is no wrap.
- Reset or flush asserted mid-stall clears everything. The first ADVANCE after deassertion loads in_* normally.
- Outputs are purely registered; there is no combinational path from any input to any output.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - perf_bubbles increments by 1 on each BUBBLE cycle that is not overridden by rst or flush.
  - perf_holds increments by 1 on each HOLD cycle that is not overridden by rst or flush.
  - Both counters saturate at 32'hFFFF_FFFF and never wrap.
  - Both are cleared only by rst; flush does not clear them.
- Undefined: both ports are tied to 32'h0 and no counter flops are synthesised. The ports remain present so the instance interface is identical in both builds.

Test Plan:
- Reset, DEPTH=1: hold rst=1 for 2 cycles with in_valid=1, in_data=all ones → out_valid=0, out_data=0, occ=0.
- Advance, DEPTH=3, stall=6'b000000: inject data 1,2,3 with valid=1 → out_data shows 1,2,3 on cycles 3,4,5; occ reaches 3.
- Bubble, DEPTH=1, STAGE_IDX=4: pipe holds 0x55 valid; apply stall=6'b011111 for 1 cycle → out_valid=0, out_data=0. Then apply stall=0 with in_data=0x66 → 0x66 appears on the next edge.
- Hold: apply stall=6'b111111 for 5 cycles with in_data changing → out_data stays at its prior value and occ is unchanged. With PIPE_STAGE_PERF_EN defined, perf_holds=5.
- Flush vs stall, DEPTH=2: both slices valid; assert flush together with stall=0 and in_valid=1 → next cycle out_valid=0 and occ=0. Data presented in the flush cycle never appears at the output.
- Perf saturation (PIPE_STAGE_PERF_EN): force perf_bubbles to 32'hFFFF_FFFE, then apply 3 BUBBLE cycles → counter reads 32'hFFFF_FFFF; rst clears it to 0.
